alu_exec_unit: RTL and testbench

- Multi-cycle ALU execute unit: the consumer end of the 5-bit ALU control code interface (the `ALU_EXEC_*` codes from types.vh).
- Accepts operands plus an exec code over a valid/ready handshake and returns a registered result over a valid/ready handshake.
- Shifts run on an iterative shifter of SHIFT_STEP bits per cycle, trading latency for area on small FPGA targets. All other ops take one cycle.
- Sits between the EX-stage operand muxes and the EX/MEM result register, and stalls the pipeline via o_ready.

---
 rtl/alu_exec_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle ALU execute unit. Accepts two operands and a 5-bit exec code
// over a valid/ready handshake and returns a registered result over a second
// valid/ready handshake. Arithmetic, logic and compare ops complete in one
// cycle; shifts iterate SHIFT_STEP bits per cycle so only a narrow shifter is
// built.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           abandon any in-flight op; same-cycle i_valid is ignored
//   i_valid, o_ready  request handshake
//   i_aluControl      exec code (see localparams below)
//   i_a, i_b          operands; shift amount is i_b[log2(XLEN)-1:0]
//   o_valid, i_ready  result handshake
//   o_result          result, held stable while o_valid && !i_ready
//   o_busy            unit is not idle
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_aluControl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  // Exec codes; any other value executes as ADD.
  localparam logic [4:0] ALU_EXEC_ADD   = 5'd0;
  localparam logic [4:0] ALU_EXEC_SUB   = 5'd1;
  localparam logic [4:0] ALU_EXEC_XOR   = 5'd2;
  localparam logic [4:0] ALU_EXEC_OR    = 5'd3;
  localparam logic [4:0] ALU_EXEC_AND   = 5'd4;
  localparam logic [4:0] ALU_EXEC_SLL   = 5'd5;
  localparam logic [4:0] ALU_EXEC_SRL   = 5'd6;
  localparam logic [4:0] ALU_EXEC_SRA   = 5'd7;
  localparam logic [4:0] ALU_EXEC_SLT   = 5'd8;
  localparam logic [4:0] ALU_EXEC_SLTU  = 5'd9;
  localparam logic [4:0] ALU_EXEC_SGTE  = 5'd10;
  localparam logic [4:0] ALU_EXEC_SGTEU = 5'd11;
  localparam logic [4:0] ALU_EXEC_EQ    = 5'd12;
  localparam logic [4:0] ALU_EXEC_NEQ   = 5'd13;
  localparam logic [4:0] ALU_EXEC_PASSB = 5'd14;
  localparam logic [4:0] ALU_EXEC_ADD4A = 5'd15;

  localparam int SHW = $clog2(XLEN);
  // One extra bit so a step of XLEN itself is representable.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_W = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_t;

  state_t          state_q, state_d;
  shift_kind_t     kind_q, kind_in;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   step_amt;
  // Doubles as the shift accumulator while in SHIFT; only observed as a
  // result once the unit reaches DONE.
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] shifted;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            start_shift;
  logic            accept;

  assign shamt       = i_b[SHW-1:0];
  assign is_shift    = (i_aluControl == ALU_EXEC_SLL) ||
                       (i_aluControl == ALU_EXEC_SRL) ||
                       (i_aluControl == ALU_EXEC_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign accept      = i_valid && o_ready && !i_flush;

  // Single-cycle datapath.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    alu_result = i_a + i_b;
    kind_in    = SH_LL;
    case (i_aluControl)
      ALU_EXEC_SUB:   alu_result = i_a - i_b;
      ALU_EXEC_XOR:   alu_result = i_a ^ i_b;
      ALU_EXEC_OR:    alu_result = i_a | i_b;
      ALU_EXEC_AND:   alu_result = i_a & i_b;
      ALU_EXEC_SLL:   alu_result = i_a;  // shamt==0 case; nonzero goes to SHIFT
      ALU_EXEC_SRL: begin
        alu_result = i_a;
        kind_in    = SH_RL;
      end
      ALU_EXEC_SRA: begin
        alu_result = i_a;
        kind_in    = SH_RA;
      end
      ALU_EXEC_SLT:   alu_result = XLEN'($signed(i_a) < $signed(i_b));
      ALU_EXEC_SLTU:  alu_result = XLEN'(i_a < i_b);
      ALU_EXEC_SGTE:  alu_result = XLEN'($signed(i_a) >= $signed(i_b));
      ALU_EXEC_SGTEU: alu_result = XLEN'(i_a >= i_b);
      ALU_EXEC_EQ:    alu_result = XLEN'(i_a == i_b);
      ALU_EXEC_NEQ:   alu_result = XLEN'(i_a != i_b);
      ALU_EXEC_PASSB: alu_result = i_b;
      ALU_EXEC_ADD4A: alu_result = i_a + XLEN'(4);
      default:        alu_result = i_a + i_b;
    endcase
  end

  // Iterative shifter: the final step may be shorter than SHIFT_STEP.
  always_comb begin
    step_amt = (cnt_q < STEP_W) ? cnt_q : STEP_W;
    case (kind_q)
      SH_RL:   shifted = result_q >> step_amt;
      SH_RA:   shifted = XLEN'($signed(result_q) >>> step_amt);
      default: shifted = result_q << step_amt;
    endcase
  end

  // State register; reset wins over flush.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state logic. DONE with i_ready behaves as IDLE so back-to-back
  // single-cycle ops sustain one result per cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == step_amt) state_d = DONE;
      DONE:    if (i_ready) state_d = accept ? (start_shift ? SHIFT : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    o_valid  = (state_q == DONE);
    o_busy   = (state_q != IDLE);
    o_result = result_q;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      result_q <= '0;
      cnt_q    <= '0;
      kind_q   <= SH_LL;
    end else if (accept) begin
      kind_q <= kind_in;
      if (start_shift) begin
        result_q <= i_a;
        cnt_q    <= CW'(shamt);
      end else begin
        result_q <= alu_result;
        cnt_q    <= '0;
      end
    end else if (state_q == SHIFT) begin
      result_q <= shifted;
      cnt_q    <= cnt_q - step_amt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed bench for alu_exec_unit. Two instances: SHIFT_STEP=1 (main) and
// SHIFT_STEP=4 (multi-bit shifter). Operands, code, flush, reset and i_ready
// are shared; each instance has its own i_valid. Inputs change 1ns after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  XOR_ = 5'd2,  OR_ = 5'd3;
  localparam logic [4:0] AND_ = 5'd4, SLL = 5'd5,  SRL = 5'd6,   SRA = 5'd7;
  localparam logic [4:0] SLT = 5'd8,  SLTU = 5'd9, SGTE = 5'd10, SGTEU = 5'd11;
  localparam logic [4:0] EQ = 5'd12,  NEQ = 5'd13, PASSB = 5'd14, ADD4A = 5'd15;

  logic        clk = 1'b0;
  logic        rst, flush, valid1, valid4, rdy_in;
  logic [4:0]  code;
  logic [31:0] a, b;
  logic        ready1, ovalid1, busy1, ready4, ovalid4, busy4;
  logic [31:0] result1, result4;
  logic        sel4;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid1),
    .o_ready(ready1), .i_aluControl(code), .i_a(a), .i_b(b),
    .o_valid(ovalid1), .i_ready(rdy_in), .o_result(result1), .o_busy(busy1)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid4),
    .o_ready(ready4), .i_aluControl(code), .i_a(a), .i_b(b),
    .o_valid(ovalid4), .i_ready(rdy_in), .o_result(result4), .o_busy(busy4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the selected instance with i_ready=1, wait (bounded) for
  // o_valid, then check latency in cycles after acceptance and the result.
  // While waiting the unit must refuse new requests.
  task automatic run_op(input string tag, input logic use4, input logic [4:0] c,
                        input logic [31:0] opa, input logic [31:0] opb,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    sel4   = use4;
    rdy_in = 1'b1;
    code   = c;
    a      = opa;
    b      = opb;
    if (use4) valid4 = 1'b1;
    else      valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    valid4 = 1'b0;
    lat = 1;
    while (!(sel4 ? ovalid4 : ovalid1) && lat < 64) begin
      check({tag, "_ready_low"}, 32'(sel4 ? ready4 : ready1), 32'd0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, sel4 ? result4 : result1, exp);
    tick();
    check({tag, "_idle_after"}, 32'(sel4 ? busy4 : busy1), 32'd0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; flush = 1'b0; valid1 = 1'b1; valid4 = 1'b1; rdy_in = 1'b1;
    code = ADD; a = 32'd1; b = 32'd1; sel4 = 1'b0;

    // Reset held two cycles with requests pending: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid",  32'(ovalid1), 32'd0);
      check("rst_result", result1,      32'd0);
      check("rst_ready",  32'(ready1),  32'd1);
      check("rst_busy",   32'(busy1),   32'd0);
    end
    rst = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
    tick();
    check("post_rst_valid", 32'(ovalid1), 32'd0);
    check("post_rst_busy",  32'(busy1),   32'd0);

    // ADD then SUB back-to-back, one result per cycle.
    code = ADD; a = 32'hFFFF_FFFF; b = 32'd1; valid1 = 1'b1;
    tick();
    check("add_valid",  32'(ovalid1), 32'd1);
    check("add_result", result1,      32'h0000_0000);
    check("add_ready",  32'(ready1),  32'd1);
    code = SUB; a = 32'd0; b = 32'd1;
    tick();
    check("sub_valid",  32'(ovalid1), 32'd1);
    check("sub_result", result1,      32'hFFFF_FFFF);
    valid1 = 1'b0;
    tick();
    check("b2b_drain_valid", 32'(ovalid1), 32'd0);

    // Compares and single-cycle ops.
    run_op("slt",   1'b0, SLT,   32'h8000_0000, 32'd1, 32'd1, 1);
    run_op("sltu",  1'b0, SLTU,  32'h8000_0000, 32'd1, 32'd0, 1);
    run_op("sgte",  1'b0, SGTE,  32'h8000_0000, 32'd1, 32'd0, 1);
    run_op("sgteu", 1'b0, SGTEU, 32'h8000_0000, 32'd1, 32'd1, 1);
    run_op("eq",    1'b0, EQ,    32'd5, 32'd5, 32'd1, 1);
    run_op("neq",   1'b0, NEQ,   32'd5, 32'd5, 32'd0, 1);
    run_op("xor",   1'b0, XOR_,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);
    run_op("or",    1'b0, OR_,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
    run_op("and",   1'b0, AND_,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    run_op("passb", 1'b0, PASSB, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    run_op("add4a", 1'b0, ADD4A, 32'hFFFF_FFFE, 32'd0, 32'h0000_0002, 1);
    run_op("undef", 1'b0, 5'd31, 32'd10, 32'd20, 32'd30, 1);

    // Serial shifts, one bit per cycle.
    run_op("sra31", 1'b0, SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31", 1'b0, SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("sll0",  1'b0, SLL, 32'h0000_1234, 32'd0,  32'h0000_1234, 1);
    run_op("sll_hi_bits_ignored", 1'b0, SLL, 32'd1, 32'h0000_0104, 32'h0000_0010, 5);

    // Four bits per cycle, including a short final step.
    run_op("s4_sll9",   1'b1, SLL, 32'd1, 32'd9, 32'h0000_0200, 4);
    run_op("s4_sra31",  1'b1, SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9);
    sel4 = 1'b0;

    // Backpressure: result held while i_ready is low; requests ignored.
    rdy_in = 1'b0;
    code = ADD; a = 32'd3; b = 32'd4; valid1 = 1'b1;
    tick();
    code = ADD; a = 32'd100; b = 32'd100;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  32'(ovalid1), 32'd1);
      check("bp_result", result1,      32'd7);
      check("bp_ready",  32'(ready1),  32'd0);
      tick();
    end
    // Release and start a new op in the same cycle.
    rdy_in = 1'b1;
    code = XOR_; a = 32'h0000_00F0; b = 32'h0000_00FF;
    tick();
    valid1 = 1'b0;
    check("bp_next_valid",  32'(ovalid1), 32'd1);
    check("bp_next_result", result1,      32'h0000_000F);
    tick();
    check("bp_drain_busy", 32'(busy1), 32'd0);

    // Flush mid-shift: back to IDLE, result cleared, no valid pulse.
    code = SRL; a = 32'hFFFF_FFFF; b = 32'd20; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick(); tick(); tick();
    check("flush_pre_busy", 32'(busy1), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy",   32'(busy1),   32'd0);
    check("flush_valid",  32'(ovalid1), 32'd0);
    check("flush_result", result1,      32'd0);
    vcount = 0;
    for (int i = 0; i < 24; i++) begin
      if (ovalid1) vcount++;
      tick();
    end
    check("flush_no_valid_pulse", 32'(vcount), 32'd0);

    // Flush in IDLE ignores a same-cycle request.
    code = ADD; a = 32'd1; b = 32'd1; valid1 = 1'b1; flush = 1'b1;
    tick();
    valid1 = 1'b0; flush = 1'b0;
    check("flush_req_ignored", 32'(busy1), 32'd0);

    run_op("after_flush", 1'b0, ADD, 32'd2, 32'd3, 32'd5, 1);

    // Reset wins over flush and aborts a shift.
    code = SLL; a = 32'd1; b = 32'd10; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    check("rst_mid_shift_busy",   32'(busy1), 32'd0);
    check("rst_mid_shift_result", result1,    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1);
  end

endmodule
